// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for the shared memory port arbiter.
// The master side drives requests and read data; the slave side is the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          vec_req;
    logic          vec_sel;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          vec_gnt;
    logic          dm_gnt;
    logic          if_gnt;
    logic          vec_rvalid;
    logic          dm_rvalid;
    logic          if_rvalid;
    logic [DW-1:0] rdata;
    logic          if_stall;
    logic          busy;

    modport master (
        output vec_req, vec_sel, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, vec_gnt, dm_gnt, if_gnt,
        input  vec_rvalid, dm_rvalid, if_rvalid, rdata, if_stall, busy
    );

    modport slave (
        input  vec_req, vec_sel, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output mem_addr, mem_we, mem_wdata, vec_gnt, dm_gnt, if_gnt,
        output vec_rvalid, dm_rvalid, if_rvalid, rdata, if_stall, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port arbiter for unified instruction/data memory: vector fetch sequencing,
// data-over-fetch priority with a starvation override, and read-return routing.
module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 3
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_ARB      = 2'd0,
        S_VEC      = 2'd1,
        S_VEC_DATA = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] starve_cnt_r;
    logic [3:0] starve_nxt_s;
    logic       vec_sel_q_r;
    logic       vec_sel_nxt_s;
    logic       vec_gnt_s;
    logic       dm_gnt_s;
    logic       if_gnt_s;
    logic       vec_rvalid_r;
    logic       dm_rvalid_r;
    logic       if_rvalid_r;

    // State, starvation counter and latched vector select
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_ARB;
            starve_cnt_r <= 4'd0;
            vec_sel_q_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            vec_sel_q_r  <= vec_sel_nxt_s;
        end
    end

    // Next-state, grant selection and starvation accounting; reset suppresses all grants
    always_comb begin
        state_nxt_s   = state_r;
        starve_nxt_s  = starve_cnt_r;
        vec_sel_nxt_s = vec_sel_q_r;
        vec_gnt_s     = 1'b0;
        dm_gnt_s      = 1'b0;
        if_gnt_s      = 1'b0;
        if (reset) begin
            state_nxt_s   = S_ARB;
            starve_nxt_s  = 4'd0;
            vec_sel_nxt_s = 1'b0;
        end else begin
            case (state_r)
                S_ARB: begin
                    if (bus.vec_req) begin
                        state_nxt_s   = S_VEC;
                        vec_sel_nxt_s = bus.vec_sel;
                    end else if (bus.if_req && (starve_cnt_r == STARVE_LIM)) begin
                        if_gnt_s = 1'b1;
                    end else if (bus.dm_req) begin
                        dm_gnt_s = 1'b1;
                    end else if (bus.if_req) begin
                        if_gnt_s = 1'b1;
                    end else begin
                        if_gnt_s = 1'b0;
                    end
                    // The drain cycle grants nothing, so the count only holds there
                    if (!bus.if_req || if_gnt_s) begin
                        starve_nxt_s = 4'd0;
                    end else if (dm_gnt_s && (starve_cnt_r < STARVE_LIM)) begin
                        starve_nxt_s = starve_cnt_r + 4'd1;
                    end else begin
                        starve_nxt_s = starve_cnt_r;
                    end
                end
                S_VEC: begin
                    vec_gnt_s   = 1'b1;
                    state_nxt_s = S_VEC_DATA;
                end
                S_VEC_DATA: begin
                    state_nxt_s = S_ARB;
                end
                default: begin
                    state_nxt_s = S_ARB;
                end
            endcase
        end
    end

    // Memory port mux driven by whichever requester holds the grant
    always_comb begin
        bus.mem_addr  = {AW{1'b0}};
        bus.mem_we    = 1'b0;
        bus.mem_wdata = {DW{1'b0}};
        if (dm_gnt_s) begin
            bus.mem_addr  = bus.dm_addr;
            bus.mem_we    = bus.dm_we;
            bus.mem_wdata = bus.dm_wdata;
        end else if (if_gnt_s) begin
            bus.mem_addr  = bus.if_addr;
        end else if (vec_gnt_s) begin
            bus.mem_addr  = {{(AW-1){1'b0}}, vec_sel_q_r};
        end else begin
            bus.mem_addr  = {AW{1'b0}};
        end
    end

    // Read-return tracking: a granted read flags its requester for the following cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_rvalid_r <= 1'b0;
            dm_rvalid_r  <= 1'b0;
            if_rvalid_r  <= 1'b0;
        end else begin
            vec_rvalid_r <= vec_gnt_s;
            dm_rvalid_r  <= dm_gnt_s & ~bus.dm_we;
            if_rvalid_r  <= if_gnt_s;
        end
    end

    // A reset cycle drops the in-flight read immediately, not one cycle later
    assign bus.vec_rvalid = vec_rvalid_r & ~reset;
    assign bus.dm_rvalid  = dm_rvalid_r & ~reset;
    assign bus.if_rvalid  = if_rvalid_r & ~reset;
    assign bus.vec_gnt    = vec_gnt_s;
    assign bus.dm_gnt     = dm_gnt_s;
    assign bus.if_gnt     = if_gnt_s;
    assign bus.rdata      = bus.mem_rdata;
    assign bus.if_stall   = bus.if_req & ~if_gnt_s;
    assign bus.busy       = (state_r != S_ARB);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous-read memory model
// preloaded with addr ^ 8'h3C.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks_cnt = 0;
    int   errors_cnt = 0;

    logic [7:0] tmem [0:255];
    logic [4:0] exp_dm_seq;
    logic [3:0] exp_st [0:4];

    mem_port_arbiter_if #(.AW(8), .DW(8)) bus ();

    mem_port_arbiter #(.AW(8), .DW(8), .STARVE_MAX(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we) tmem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= tmem[bus.mem_addr];
    end

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tmem[i] = 8'(i) ^ 8'h3C;
        exp_dm_seq = 5'b10111;
        exp_st     = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        reset        = 1'b1;
        bus.vec_req  = 1'b0;
        bus.vec_sel  = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = 8'h00;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 8'h00;
        bus.dm_wdata = 8'h00;
        next_cycle;
        next_cycle;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_busy", 8'(bus.busy), 8'd0);
        check_eq("rst_gnts", 8'({bus.vec_gnt, bus.dm_gnt, bus.if_gnt}), 8'd0);
        check_eq("rst_rvalid", 8'({bus.vec_rvalid, bus.dm_rvalid, bus.if_rvalid}), 8'd0);
        check_eq("rst_addr", bus.mem_addr, 8'h00);
        check_eq("rst_starve", 8'(dut.starve_cnt_r), 8'd0);
        next_cycle;

        // Test 1: fetch-only stream from PC 0x05
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h05;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t1_if_gnt", 8'(bus.if_gnt), 8'd1);
            check_eq("t1_addr", bus.mem_addr, 8'h05);
            check_eq("t1_we", 8'(bus.mem_we), 8'd0);
            check_eq("t1_stall", 8'(bus.if_stall), 8'd0);
            if (k > 0) begin
                check_eq("t1_if_rvalid", 8'(bus.if_rvalid), 8'd1);
                check_eq("t1_rdata", bus.rdata, 8'h39);
            end
            next_cycle;
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        check_eq("t1_if_rvalid_last", 8'(bus.if_rvalid), 8'd1);
        check_eq("t1_rdata_last", bus.rdata, 8'h39);
        check_eq("t1_idle_gnt", 8'(bus.if_gnt), 8'd0);
        check_eq("t1_idle_addr", bus.mem_addr, 8'h00);
        next_cycle;

        // Test 2: data write beats fetch
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 8'hF0;
        bus.dm_wdata = 8'hAA;
        bus.if_req   = 1'b1;
        @(negedge clk);
        check_eq("t2_dm_gnt", 8'(bus.dm_gnt), 8'd1);
        check_eq("t2_if_gnt", 8'(bus.if_gnt), 8'd0);
        check_eq("t2_we", 8'(bus.mem_we), 8'd1);
        check_eq("t2_addr", bus.mem_addr, 8'hF0);
        check_eq("t2_wdata", bus.mem_wdata, 8'hAA);
        check_eq("t2_stall", 8'(bus.if_stall), 8'd1);
        next_cycle;
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        bus.if_req = 1'b0;
        @(negedge clk);
        check_eq("t2_no_rvalid", 8'({bus.vec_rvalid, bus.dm_rvalid, bus.if_rvalid}), 8'd0);
        check_eq("t2_starve", 8'(dut.starve_cnt_r), 8'd1);
        next_cycle;

        // Test 3: starvation override with dm read of 0xF0 and fetch both held
        bus.dm_req  = 1'b1;
        bus.dm_addr = 8'hF0;
        bus.if_req  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("t3_starve", 8'(dut.starve_cnt_r), 8'(exp_st[c]));
            check_eq("t3_dm_gnt", 8'(bus.dm_gnt), 8'(exp_dm_seq[c]));
            check_eq("t3_if_gnt", 8'(bus.if_gnt), 8'(!exp_dm_seq[c]));
            check_eq("t3_stall", 8'(bus.if_stall), 8'(exp_dm_seq[c]));
            if (c > 0) begin
                check_eq("t3_dm_rvalid", 8'(bus.dm_rvalid), 8'(exp_dm_seq[c-1]));
                check_eq("t3_if_rvalid", 8'(bus.if_rvalid), 8'(!exp_dm_seq[c-1]));
                check_eq("t3_rdata", bus.rdata, exp_dm_seq[c-1] ? 8'hAA : 8'h39);
            end
            next_cycle;
        end
        bus.dm_req = 1'b0;
        bus.if_req = 1'b0;
        @(negedge clk);
        check_eq("t3_dm_rvalid_last", 8'(bus.dm_rvalid), 8'd1);
        check_eq("t3_rdata_last", bus.rdata, 8'hAA);
        next_cycle;

        // Test 4: interrupt vector fetch with a pending dm read of 0x10
        bus.vec_req = 1'b1;
        bus.vec_sel = 1'b1;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 8'h10;
        @(negedge clk);
        check_eq("t4_n_gnts", 8'({bus.vec_gnt, bus.dm_gnt, bus.if_gnt}), 8'd0);
        check_eq("t4_n_busy", 8'(bus.busy), 8'd0);
        check_eq("t4_n_addr", bus.mem_addr, 8'h00);
        next_cycle;
        @(negedge clk);
        check_eq("t4_n1_vec_gnt", 8'(bus.vec_gnt), 8'd1);
        check_eq("t4_n1_dm_gnt", 8'(bus.dm_gnt), 8'd0);
        check_eq("t4_n1_addr", bus.mem_addr, 8'h01);
        check_eq("t4_n1_busy", 8'(bus.busy), 8'd1);
        next_cycle;
        bus.vec_req = 1'b0;
        @(negedge clk);
        check_eq("t4_n2_vec_rvalid", 8'(bus.vec_rvalid), 8'd1);
        check_eq("t4_n2_rdata", bus.rdata, 8'h3D);
        check_eq("t4_n2_gnts", 8'({bus.vec_gnt, bus.dm_gnt, bus.if_gnt}), 8'd0);
        check_eq("t4_n2_busy", 8'(bus.busy), 8'd1);
        next_cycle;
        @(negedge clk);
        check_eq("t4_n3_dm_gnt", 8'(bus.dm_gnt), 8'd1);
        check_eq("t4_n3_addr", bus.mem_addr, 8'h10);
        check_eq("t4_n3_busy", 8'(bus.busy), 8'd0);
        check_eq("t4_n3_vec_rvalid", 8'(bus.vec_rvalid), 8'd0);
        next_cycle;

        // Test 5: reset right after a granted dm read drops its return
        bus.dm_req = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        check_eq("t5_n1_dm_rvalid", 8'(bus.dm_rvalid), 8'd0);
        check_eq("t5_n1_gnts", 8'({bus.vec_gnt, bus.dm_gnt, bus.if_gnt}), 8'd0);
        next_cycle;
        reset = 1'b0;
        @(negedge clk);
        check_eq("t5_n2_dm_rvalid", 8'(bus.dm_rvalid), 8'd0);
        check_eq("t5_n2_busy", 8'(bus.busy), 8'd0);
        check_eq("t5_n2_starve", 8'(dut.starve_cnt_r), 8'd0);
        next_cycle;

        // Test 6: reset vector request colliding with reset
        bus.vec_req = 1'b1;
        bus.vec_sel = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_vec_gnt", 8'(bus.vec_gnt), 8'd0);
        next_cycle;
        reset = 1'b0;
        @(negedge clk);
        check_eq("t6_drain_busy", 8'(bus.busy), 8'd0);
        check_eq("t6_drain_vec_gnt", 8'(bus.vec_gnt), 8'd0);
        next_cycle;
        bus.vec_req = 1'b0;
        @(negedge clk);
        check_eq("t6_vec_gnt", 8'(bus.vec_gnt), 8'd1);
        check_eq("t6_addr", bus.mem_addr, 8'h00);
        check_eq("t6_busy", 8'(bus.busy), 8'd1);
        next_cycle;
        @(negedge clk);
        check_eq("t6_vec_rvalid", 8'(bus.vec_rvalid), 8'd1);
        check_eq("t6_rdata", bus.rdata, 8'h3C);
        next_cycle;
        @(negedge clk);
        check_eq("t6_resume_busy", 8'(bus.busy), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-port arbiter and sequencer for the unified instruction/data memory.
- Shares the one memory port between three requesters:
  - vector fetch from the PC control unit: reset vector M[0], interrupt vector M[1];
  - data-memory accesses from the MEM stage: LDD/STD/PUSH/POP/CALL/RET;
  - instruction fetch at the PC.
- Drives memory address, write enable and write data.
- Routes synchronous-read return data back to the requester that issued the read.
- Raises if_stall so the PC control unit holds the PC while fetch is blocked.

Parameters:
- AW, 8, memory address width.
- DW, 8, memory data width.
- STARVE_MAX, 3, consecutive fetch denials caused by data accesses after which fetch wins one cycle (range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- vec_req  in  1  vector fetch request (pulse or level).
- vec_sel  in  1  0 = reset vector at address 0, 1 = interrupt vector at address 1.
- if_req  in  1  instruction fetch request.
- if_addr  in  AW  fetch address (PC).
- dm_req  in  1  data access request.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- mem_rdata  in  DW  memory read data, valid the cycle after the address.
- mem_addr  out  AW  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DW  memory write data.
- vec_gnt, dm_gnt, if_gnt  out  1 each  combinational grant; at most one high per cycle.
- vec_rvalid, dm_rvalid, if_rvalid  out  1 each  registered; read data for that requester is on rdata this cycle.
- rdata  out  DW  equals mem_rdata.
- if_stall  out  1  if_req high and if_gnt low.
- busy  out  1  state is not S_ARB.

Behaviour:
- Reset (synchronous, active-high; overrides everything):
  - state goes to S_ARB; starve_cnt, vec_sel_q and all rvalid registers clear to 0.
  - An in-flight read is dropped: no rvalid is asserted after a reset cycle.
- No-grant cycle: mem_addr=0, mem_we=0, mem_wdata=0, all gnt=0.
- S_ARB, vec_req=1:
  - no grants this cycle (drain cycle); if_stall follows if_req.
  - vec_sel_q <= vec_sel; next state S_VEC.
- S_ARB, vec_req=0: priority is dm > if, with a starvation override.
  - If if_req=1 and starve_cnt==STARVE_MAX: if wins.
  - Otherwise if dm_req=1: dm wins; mem_addr=dm_addr, mem_we=dm_we, mem_wdata=dm_wdata.
  - Otherwise if if_req=1: if wins; mem_addr=if_addr, mem_we=0.
- S_VEC:
  - vec_gnt=1; mem_addr={AW-1 zeros, vec_sel_q}; mem_we=0; no other grants.
  - vec_req is ignored. Next state S_VEC_DATA.
- S_VEC_DATA:
  - vec_rvalid=1 (registered from S_VEC); no grants (bubble for PC load). Next state S_ARB.
- Read return: a granted read (dm read, if, vec) sets the matching *_rvalid register high for exactly the next cycle. Writes never set rvalid. Back-to-back reads pipeline at one per cycle.
- starve_cnt:
  - increments (saturating at STARVE_MAX) in S_ARB when if_req=1 and dm wins;
  - clears when if_gnt=1 or if_req=0;
  - holds in S_VEC and S_VEC_DATA.
- Simultaneous dm_req and if_req: dm granted, if_stall=1, unless the starvation override applies.
- When fetch wins by starvation override while dm_req=1: dm_gnt=0, and the requester must hold dm_req.
- vec_req asserted in the same cycle as reset: reset wins; vec_req is re-sampled in the next S_ARB cycle.
- Latency:
  - dm and if: grant in cycle N, rdata/rvalid in N+1.
  - vec: request in N, address in N+1, data in N+2, arbitration resumes in N+3.

Test Plan:
1. Reset, then if_req=1, if_addr=8'h05, dm_req=0 for 3 cycles -> if_gnt=1 each cycle, mem_addr=05, if_rvalid=1 in cycles 2-4, rdata=mem_rdata.
2. dm_req=1, dm_we=1, dm_addr=8'hF0, dm_wdata=8'hAA, if_req=1 -> dm_gnt=1, mem_we=1, mem_addr=F0, mem_wdata=AA, if_stall=1, no rvalid next cycle.
3. dm_req and if_req held high, STARVE_MAX=3 -> dm_gnt for 3 cycles, then if_gnt for 1 cycle with if_stall=0, then dm_gnt again; starve_cnt back to 0.
4. vec_req=1, vec_sel=1 in cycle N -> no grants in N, vec_gnt=1 with mem_addr=01 in N+1, vec_rvalid=1 in N+2, dm_req granted no earlier than N+3; busy=1 in N+1..N+2.
5. dm read at dm_addr=8'h10 granted in N, reset=1 in N+1 -> dm_rvalid=0 in N+1 and N+2, state S_ARB, starve_cnt=0.
6. vec_req=1 and reset=1 in the same cycle -> stays in S_ARB with no vec_gnt; vec_req held into the next cycle -> S_VEC entered one cycle later.
